// File: rtl/dm_cache.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache
//  Description : Direct-mapped, one-word-per-line, write-through /
//                no-write-allocate data cache with load hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_cache #(
    parameter int NLINES = 16,
    parameter int AW     = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    localparam int c_IW = $clog2(NLINES);
    localparam int c_TW = AW - c_IW;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RDMISS = 2'd1;
    localparam logic [1:0] c_ST_WRTHRU = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_fill;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;
    logic [NLINES-1:0] r_valid;
    logic [c_TW-1:0]   r_tag  [NLINES];
    logic [31:0]       r_data [NLINES];

    logic [c_IW-1:0]   w_idx;
    logic [c_TW-1:0]   w_tag;
    logic [c_IW-1:0]   w_fill_idx;
    logic [c_TW-1:0]   w_fill_tag;
    logic              w_idle;
    logic              w_busy;
    logic              w_hit;
    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_rd_hit;
    logic              w_rd_miss;
    logic              w_fill;

    assign w_idx      = cpu_addr[c_IW-1:0];
    assign w_tag      = cpu_addr[AW-1:c_IW];
    assign w_fill_idx = r_addr[c_IW-1:0];
    assign w_fill_tag = r_addr[AW-1:c_IW];

    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_busy    = (r_state == c_ST_RDMISS) || (r_state == c_ST_WRTHRU);
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // A store wins over a simultaneous load; the load is simply dropped.
    assign w_wr_req  = w_idle && cpu_wr;
    assign w_rd_req  = w_idle && cpu_rd && !cpu_wr;
    assign w_rd_hit  = w_rd_req && w_hit;
    assign w_rd_miss = w_rd_req && !w_hit;
    assign w_fill    = (r_state == c_ST_RDMISS) && mem_ack;

    assign cpu_stall = w_wr_req || w_rd_miss || w_busy;
    assign mem_req   = w_busy;
    assign mem_we    = (r_state == c_ST_WRTHRU);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    always_comb begin
        cpu_rdata = 32'd0;
        if (w_rd_hit) begin
            cpu_rdata = r_data[w_idx];
        end else if (r_state == c_ST_DONE) begin
            cpu_rdata = r_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_fill     <= 32'd0;
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
            r_valid    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cpu_wr) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_state <= c_ST_WRTHRU;
                    end else if (cpu_rd) begin
                        if (w_hit) begin
                            if (r_hit_cnt != 16'hFFFF) begin
                                r_hit_cnt <= r_hit_cnt + 16'd1;
                            end
                        end else begin
                            r_addr <= cpu_addr;
                            if (r_miss_cnt != 16'hFFFF) begin
                                r_miss_cnt <= r_miss_cnt + 16'd1;
                            end
                            r_state <= c_ST_RDMISS;
                        end
                    end
                end
                c_ST_RDMISS: begin
                    if (mem_ack) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_fill              <= mem_rdata;
                        r_state             <= c_ST_DONE;
                    end
                end
                c_ST_WRTHRU: begin
                    if (mem_ack) begin
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Tag/data storage needs no reset: nothing reads it until a valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_req && w_hit) begin
            r_data[w_idx] <= cpu_wdata;
        end else if (w_fill) begin
            r_data[w_fill_idx] <= mem_rdata;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache
//  Description : Directed self-checking bench for dm_cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cpu_rd    = 1'b0;
    logic        cpu_wr    = 1'b0;
    logic [6:0]  cpu_addr  = 7'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int tests = 0;
    int fails = 0;

    dm_cache #(.NLINES(16), .AW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Acks a pending request one cycle after it was issued, lets DONE pass,
    // then drops the CPU request.
    task automatic complete_op(input logic [31:0] data);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        @(negedge clk);
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b expected 0", cpu_stall); end
        tests++; if (hit_cnt !== 16'd0) begin fails++; $display("FAIL reset_hit_cnt: got %h expected 0000", hit_cnt); end
        tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL reset_miss_cnt: got %h expected 0000", miss_cnt); end
        tests++; if (cpu_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", cpu_rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_load();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL cold_stall_t: got %0b expected 1", cpu_stall); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL cold_req_t: got %0b expected 0", mem_req); end
        @(posedge clk); #1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL cold_req: got %0b expected 1", mem_req); end
        tests++; if (mem_addr !== 7'h05) begin fails++; $display("FAIL cold_addr: got %h expected 05", mem_addr); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL cold_we: got %0b expected 0", mem_we); end
        tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++; if (mem_req !== 1'b1 || cpu_stall !== 1'b1) begin
                fails++; $display("FAIL cold_wait%0d: req=%0b stall=%0b expected 1 1", i, mem_req, cpu_stall);
            end
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL cold_ack_stall: got %0b expected 1", cpu_stall); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cold_done_stall: got %0b expected 0", cpu_stall); end
        tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL cold_done_rdata: got %h expected deadbeef", cpu_rdata); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL cold_done_req: got %0b expected 0", mem_req); end
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic test_hit();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL hit_stall: got %0b expected 0", cpu_stall); end
        tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL hit_rdata: got %h expected deadbeef", cpu_rdata); end
        @(posedge clk); #1;
        tests++; if (hit_cnt !== 16'd1) begin fails++; $display("FAIL hit_cnt: got %0d expected 1", hit_cnt); end
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        tests++; if (cpu_rdata !== 32'd0) begin fails++; $display("FAIL idle_rdata: got %h expected 00000000", cpu_rdata); end
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h15;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL conflict_stall: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (mem_addr !== 7'h15) begin fails++; $display("FAIL conflict_addr: got %h expected 15", mem_addr); end
        complete_op(32'hCAFEF00D);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL replaced_stall: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (miss_cnt !== 16'd3) begin fails++; $display("FAIL replaced_miss_cnt: got %0d expected 3", miss_cnt); end
        complete_op(32'hDEADBEEF);
    endtask

    task automatic test_write_through();
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 7'h05; cpu_wdata = 32'h12345678;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL wr_stall: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            fails++; $display("FAIL wr_req_we: req=%0b we=%0b expected 1 1", mem_req, mem_we);
        end
        tests++; if (mem_wdata !== 32'h12345678) begin fails++; $display("FAIL wr_wdata: got %h expected 12345678", mem_wdata); end
        tests++; if (mem_addr !== 7'h05) begin fails++; $display("FAIL wr_addr: got %h expected 05", mem_addr); end
        complete_op(32'd0);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h12345678) begin
            fails++; $display("FAIL wr_readback: stall=%0b rdata=%h expected 0 12345678", cpu_stall, cpu_rdata);
        end
        @(posedge clk); #1;
        tests++; if (hit_cnt !== 16'd2) begin fails++; $display("FAIL wr_hit_cnt: got %0d expected 2", hit_cnt); end
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 7'h0A; cpu_wdata = 32'h0BADF00D;
        complete_op(32'd0);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h0A;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL no_alloc_stall: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (miss_cnt !== 16'd4) begin fails++; $display("FAIL no_alloc_miss_cnt: got %0d expected 4", miss_cnt); end
        complete_op(32'h0A0A0A0A);
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h09;
        complete_op(32'h99999999);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 7'h09; cpu_wdata = 32'h55AA55AA;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL rdwr_stall: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            fails++; $display("FAIL rdwr_wrthru: req=%0b we=%0b expected 1 1", mem_req, mem_we);
        end
        tests++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd5) begin
            fails++; $display("FAIL rdwr_counters: hit=%0d miss=%0d expected 2 5", hit_cnt, miss_cnt);
        end
        complete_op(32'd0);
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h09;
        #1;
        tests++; if (cpu_rdata !== 32'h55AA55AA) begin fails++; $display("FAIL rdwr_readback: got %h expected 55aa55aa", cpu_rdata); end
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h0A;
        #1;
        tests++; if (cpu_rdata !== 32'h0A0A0A0A) begin fails++; $display("FAIL b2b_0a: got %h expected 0a0a0a0a", cpu_rdata); end
        @(negedge clk);
        cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_rdata !== 32'h12345678) begin fails++; $display("FAIL b2b_05: got %h expected 12345678", cpu_rdata); end
        @(negedge clk);
        cpu_addr = 7'h09;
        #1;
        tests++; if (cpu_rdata !== 32'h55AA55AA || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL b2b_09: rdata=%h stall=%0b expected 55aa55aa 0", cpu_rdata, cpu_stall);
        end
        @(posedge clk); #1;
        tests++; if (hit_cnt !== 16'd6) begin fails++; $display("FAIL b2b_hit_cnt: got %0d expected 6", hit_cnt); end
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h25;
        @(posedge clk); #1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL midrst_pre_req: got %0b expected 1", mem_req); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            fails++; $display("FAIL midrst_req: req=%0b we=%0b expected 0 0", mem_req, mem_we);
        end
        tests++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            fails++; $display("FAIL midrst_counters: hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
        end
        @(negedge clk);
        cpu_rd = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        tests++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            fails++; $display("FAIL stray_ack: req=%0b stall=%0b expected 0 0", mem_req, cpu_stall);
        end
        @(negedge clk);
        mem_ack = 1'b0; cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL midrst_remiss: got %0b expected 1", cpu_stall); end
        @(posedge clk); #1;
        tests++; if (miss_cnt !== 16'd1 || mem_addr !== 7'h05) begin
            fails++; $display("FAIL midrst_refill: miss=%0d addr=%h expected 1 05", miss_cnt, mem_addr);
        end
        complete_op(32'hDEADBEEF);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 7'h05;
        #1;
        tests++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL sat_first_hit: stall=%0b rdata=%h expected 0 deadbeef", cpu_stall, cpu_rdata);
        end
        repeat (65534) @(posedge clk);
        #1;
        tests++; if (hit_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_near: got %h expected fffe", hit_cnt); end
        repeat (6) @(posedge clk);
        #1;
        tests++; if (hit_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h expected ffff", hit_cnt); end
        tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL sat_miss_cnt: got %0d expected 1", miss_cnt); end
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_hit();
        test_write_through();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_miss();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
